owm_byte_sequencer: RTL and testbench

Byte-level command sequencer for the 1-wire master bit engine. It accepts reset, write-byte, read-byte and CRC-clear commands on a valid/ready port and expands each byte into eight LSB-first bit slots on the engine's single-bit request interface. It accumulates the Dallas/Maxim CRC-8 over every transferred bit and returns one response pulse per command. It sits between the Avalon-MM register front end and the bit engine, so software no longer polls STAT once per bit.

---
 rtl/owm_byte_sequencer_if.sv | 27 ++
 rtl/owm_byte_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_owm_byte_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/owm_byte_sequencer_if.sv
// Command/response port of the 1-wire byte sequencer.
// The register front end is the master; the sequencer is the slave.
interface owm_byte_sequencer_if #(
    parameter int BUS_W = 1
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [BUS_W-1:0] cmd_bus;
    logic [7:0]       cmd_data;
    logic             rsp_valid;
    logic [7:0]       rsp_data;
    logic             rsp_presence;
    logic [7:0]       rsp_crc;
    logic             rsp_crc_ok;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_bus, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_crc, rsp_crc_ok, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_bus, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_crc, rsp_crc_ok, rsp_err
    );
endinterface

// File: rtl/owm_byte_sequencer.sv
// Byte-level command sequencer for the 1-wire master bit engine.
// Expands reset / write-byte / read-byte commands into LSB-first bit slots,
// keeps a running Dallas/Maxim CRC-8 and returns one response per command.
module owm_byte_sequencer #(
    parameter int OWM_BUS_NUM = 1,
    parameter int BUS_W       = (OWM_BUS_NUM == 1) ? 1 : $clog2(OWM_BUS_NUM)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    owm_byte_sequencer_if.slave      cmd_if,
    output logic [BUS_W-1:0]         bit_bus,
    output logic                     bit_reset_req,
    output logic                     bit_write_req,
    output logic                     bit_read_req,
    output logic                     bit_wdat,
    input  logic                     bit_busy,
    input  logic                     bit_done,
    input  logic                     bit_rdat,
    input  logic                     bit_presence,
    output logic                     busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    // One extra bit so a bus count equal to 2**BUS_W still fits.
    localparam logic [BUS_W:0] BUS_LIMIT = (BUS_W + 1)'(OWM_BUS_NUM);

    // One step of the reflected CRC-8 (x^8 + x^5 + x^4 + 1), shifted LSB first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic b);
        logic fb;
        fb        = crc_in[0] ^ b;
        crc8_step = {1'b0, crc_in[7:1]} ^ (fb ? 8'h8C : 8'h00);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [BUS_W-1:0] bus_q, bus_d;
    logic [7:0]       data_q, data_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       crc_q, crc_d;
    logic             presence_q, presence_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [7:0]       rsp_crc_q, rsp_crc_d;
    logic             rsp_crc_ok_q, rsp_crc_ok_d;
    logic             rsp_err_q, rsp_err_d;

    logic             bus_bad_s;
    logic             issue_s;
    logic             slot_bit_s;

    assign bus_bad_s  = {1'b0, cmd_if.cmd_bus} >= BUS_LIMIT;
    assign issue_s    = (state_q == ST_ISSUE) && !bit_busy;
    assign slot_bit_s = (op_q == OP_READ) ? bit_rdat : data_q[0];

    // Next-state, datapath and response-register logic.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        bus_d        = bus_q;
        data_d       = data_q;
        bit_cnt_d    = bit_cnt_q;
        crc_d        = crc_q;
        presence_d   = presence_q;
        rsp_data_d   = rsp_data_q;
        rsp_crc_d    = rsp_crc_q;
        rsp_crc_ok_d = rsp_crc_ok_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_if.cmd_valid) begin
                    op_d      = cmd_if.cmd_op;
                    bus_d     = cmd_if.cmd_bus;
                    data_d    = cmd_if.cmd_data;
                    bit_cnt_d = 3'd0;
                    if (bus_bad_s || (cmd_if.cmd_op == OP_CLEAR)) begin
                        // A rejected command must not touch the CRC.
                        if (!bus_bad_s) begin
                            crc_d = 8'h00;
                        end else begin
                            crc_d = crc_q;
                        end
                        state_d      = ST_RESP;
                        rsp_data_d   = 8'h00;
                        rsp_err_d    = bus_bad_s;
                        rsp_crc_d    = crc_d;
                        rsp_crc_ok_d = (crc_d == 8'h00);
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!bit_busy) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bit_done) begin
                    case (op_q)
                        OP_RESET: begin
                            presence_d   = bit_presence;
                            state_d      = ST_RESP;
                            rsp_data_d   = 8'h00;
                            rsp_err_d    = 1'b0;
                            rsp_crc_d    = crc_q;
                            rsp_crc_ok_d = (crc_q == 8'h00);
                        end
                        OP_WRITE, OP_READ: begin
                            crc_d = crc8_step(crc_q, slot_bit_s);
                            if (op_q == OP_READ) begin
                                data_d = {bit_rdat, data_q[7:1]};
                            end else begin
                                data_d = {1'b0, data_q[7:1]};
                            end
                            if (bit_cnt_q == 3'd7) begin
                                state_d      = ST_RESP;
                                rsp_data_d   = (op_q == OP_READ) ? data_d : 8'h00;
                                rsp_err_d    = 1'b0;
                                rsp_crc_d    = crc_d;
                                rsp_crc_ok_d = (crc_d == 8'h00);
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                                state_d   = ST_ISSUE;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            op_q         <= 2'd0;
            bus_q        <= '0;
            data_q       <= 8'h00;
            bit_cnt_q    <= 3'd0;
            crc_q        <= 8'h00;
            presence_q   <= 1'b0;
            rsp_data_q   <= 8'h00;
            rsp_crc_q    <= 8'h00;
            rsp_crc_ok_q <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            bus_q        <= bus_d;
            data_q       <= data_d;
            bit_cnt_q    <= bit_cnt_d;
            crc_q        <= crc_d;
            presence_q   <= presence_d;
            rsp_data_q   <= rsp_data_d;
            rsp_crc_q    <= rsp_crc_d;
            rsp_crc_ok_q <= rsp_crc_ok_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Request pulses fire in the ISSUE cycle once the engine is free.
    assign bit_reset_req = issue_s && (op_q == OP_RESET);
    assign bit_write_req = issue_s && (op_q == OP_WRITE);
    assign bit_read_req  = issue_s && (op_q == OP_READ);
    assign bit_wdat      = bit_write_req && data_q[0];
    assign bit_bus       = bus_q;
    assign busy          = (state_q != ST_IDLE);

    assign cmd_if.cmd_ready    = (state_q == ST_IDLE);
    assign cmd_if.rsp_valid    = (state_q == ST_RESP);
    assign cmd_if.rsp_data     = rsp_data_q;
    assign cmd_if.rsp_presence = presence_q;
    assign cmd_if.rsp_crc      = rsp_crc_q;
    assign cmd_if.rsp_crc_ok   = rsp_crc_ok_q;
    assign cmd_if.rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_owm_byte_sequencer.sv
// Scoreboard bench for owm_byte_sequencer with a small bit-engine model.
module tb_owm_byte_sequencer;

    localparam int NB = 3;
    localparam int BW = 2;

    logic          clock;
    logic          reset_n;
    logic [BW-1:0] bit_bus;
    logic          bit_reset_req, bit_write_req, bit_read_req, bit_wdat;
    logic          bit_busy, bit_done, bit_rdat, bit_presence;
    logic          busy;

    owm_byte_sequencer_if #(.BUS_W(BW)) sif ();

    owm_byte_sequencer #(.OWM_BUS_NUM(NB), .BUS_W(BW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cmd_if       (sif),
        .bit_bus      (bit_bus),
        .bit_reset_req(bit_reset_req),
        .bit_write_req(bit_write_req),
        .bit_read_req (bit_read_req),
        .bit_wdat     (bit_wdat),
        .bit_busy     (bit_busy),
        .bit_done     (bit_done),
        .bit_rdat     (bit_rdat),
        .bit_presence (bit_presence),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       pres;
        logic [7:0] crc;
        logic       ok;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   rsp_cnt = 0;
    int   exp_cnt = 0;
    int   rsp_cyc = 0;
    int   acc_cyc = 0;

    // engine model state
    logic [7:0]    rd_byte = 8'h00;
    logic          pres_val = 1'b0;
    logic [BW-1:0] cur_bus = '0;
    int            busy_before = -1;
    int            req_idx = 0, pend_idx = 0, pend_cnt = 0, busy_left = 0;
    int            n_wr = 0, n_rd = 0, n_rst = 0;
    logic          wbits[$];
    int            req_cyc[$];

    logic [7:0] exp_crc = 8'h00;
    logic       exp_pres = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = {1'b0, r[7:1]} ^ 8'h8C;
            else             r = {1'b0, r[7:1]};
        end
        return r;
    endfunction

    // Bit engine: log requests at negedge, answer two cycles later.
    initial begin
        bit_busy = 1'b0; bit_done = 1'b0; bit_rdat = 1'b0; bit_presence = 1'b0;
        forever begin
            @(negedge clock);
            if (bit_write_req || bit_read_req || bit_reset_req) begin
                if (bit_write_req) begin n_wr++; wbits.push_back(bit_wdat); end
                if (bit_read_req)  n_rd++;
                if (bit_reset_req) n_rst++;
                req_cyc.push_back(cyc);
                chk("bit_bus", 32'(bit_bus), 32'(cur_bus));
                pend_idx = req_idx;
                req_idx++;
                pend_cnt = 2;
            end
            @(posedge clock);
            #1;
            if (busy_left > 0) begin bit_busy = 1'b1; busy_left--; end
            else bit_busy = 1'b0;
            bit_done = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bit_done     = 1'b1;
                    bit_rdat     = rd_byte[pend_idx[2:0]];
                    bit_presence = pres_val;
                    if (pend_idx + 1 == busy_before) busy_left = 5;
                end
            end
        end
    end

    // Response monitor: pop the scoreboard on every rsp_valid.
    always @(negedge clock) begin
        if (reset_n && sif.rsp_valid) begin
            rsp_t e;
            rsp_cnt++;
            rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data",     32'(sif.rsp_data),     32'(e.data));
                chk("rsp_presence", 32'(sif.rsp_presence), 32'(e.pres));
                chk("rsp_crc",      32'(sif.rsp_crc),      32'(e.crc));
                chk("rsp_crc_ok",   32'(sif.rsp_crc_ok),   32'(e.ok));
                chk("rsp_err",      32'(sif.rsp_err),      32'(e.err));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [BW-1:0] bus, input logic [7:0] data);
        int n;
        n = 0;
        @(negedge clock);
        while (!sif.cmd_ready && n < 200) begin n++; @(negedge clock); end
        if (n >= 200) chk("ready_timeout", 32'(sif.cmd_ready), 32'd1);
        wbits.delete(); req_cyc.delete();
        n_wr = 0; n_rd = 0; n_rst = 0; req_idx = 0;
        cur_bus = bus;
        @(posedge clock);
        #1;
        sif.cmd_valid = 1'b1; sif.cmd_op = op; sif.cmd_bus = bus; sif.cmd_data = data;
        acc_cyc = cyc;
        @(posedge clock);
        #1;
        sif.cmd_valid = 1'b0;
    endtask

    task automatic run(input logic [1:0] op, input logic [BW-1:0] bus, input logic [7:0] data,
                       input logic [7:0] e_data, input logic [7:0] e_crc, input logic e_err);
        rsp_t e;
        int   n;
        e.data = e_data; e.pres = exp_pres; e.crc = e_crc; e.ok = (e_crc == 8'h00); e.err = e_err;
        exp_q.push_back(e);
        exp_cnt++;
        send(op, bus, data);
        n = 0;
        while (rsp_cnt < exp_cnt && n < 500) begin @(negedge clock); n++; end
        if (rsp_cnt < exp_cnt) chk("rsp_timeout", 32'(rsp_cnt), 32'(exp_cnt));
        @(negedge clock);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wexp;
        logic [7:0] rom [8];
        logic [7:0] e;
        int n;
        rom = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};
        sif.cmd_valid = 1'b0; sif.cmd_op = 2'd0; sif.cmd_bus = '0; sif.cmd_data = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("rst_cmd_ready", 32'(sif.cmd_ready),  32'd1);
        chk("rst_busy",      32'(busy),           32'd0);
        chk("rst_rsp_valid", 32'(sif.rsp_valid),  32'd0);
        chk("rst_rsp_crc",   32'(sif.rsp_crc),    32'd0);
        chk("rst_crc_ok",    32'(sif.rsp_crc_ok), 32'd0);
        chk("rst_presence",  32'(sif.rsp_presence), 32'd0);
        chk("rst_reqs",      32'({bit_reset_req, bit_write_req, bit_read_req}), 32'd0);

        // write 0xA5 on bus 0
        e = ref_crc(exp_crc, 8'hA5);
        run(2'd1, 2'd0, 8'hA5, 8'h00, e, 1'b0);
        exp_crc = e;
        wexp = 8'hA5;
        chk("wr_count", 32'(n_wr), 32'd8);
        chk("wr_no_rd", 32'(n_rd + n_rst), 32'd0);
        for (int i = 0; i < 8; i++) chk("wr_bit", 32'(wbits[i]), 32'(wexp[i]));
        chk("wr_first_req", 32'(req_cyc[0] - acc_cyc), 32'd1);
        chk("wr_rsp_lat", 32'(rsp_cyc - req_cyc[7]), 32'd3);

        // read 0x3C on bus 1 with engine busy for 5 cycles before bit 3
        rd_byte = 8'h3C; busy_before = 3;
        e = ref_crc(exp_crc, 8'h3C);
        run(2'd2, 2'd1, 8'hFF, 8'h3C, e, 1'b0);
        exp_crc = e;
        busy_before = -1;
        chk("rd_count", 32'(n_rd), 32'd8);
        chk("rd_gap_norm", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
        chk("rd_gap_busy", 32'(req_cyc[3] - req_cyc[2]), 32'd8);

        // CRC clear then 1-wire ROM code
        exp_crc = 8'h00;
        run(2'd3, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("clr_lat", 32'(rsp_cyc - acc_cyc), 32'd1);
        chk("clr_reqs", 32'(req_cyc.size()), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_byte = rom[i];
            e = ref_crc(exp_crc, rom[i]);
            if (i == 6) e = 8'hA2;
            if (i == 7) e = 8'h00;
            run(2'd2, 2'd0, 8'h00, rom[i], e, 1'b0);
            exp_crc = e;
        end

        // reset slots: presence 1 then 0, CRC untouched
        pres_val = 1'b1; exp_pres = 1'b1;
        run(2'd0, 2'd1, 8'h00, 8'h00, exp_crc, 1'b0);
        chk("rst1_count", 32'(n_rst), 32'd1);
        chk("rst1_other", 32'(n_wr + n_rd), 32'd0);
        pres_val = 1'b0; exp_pres = 1'b0;
        run(2'd0, 2'd2, 8'h00, 8'h00, exp_crc, 1'b0);
        chk("rst0_count", 32'(n_rst), 32'd1);

        // out-of-range bus, then the highest valid bus
        run(2'd1, 2'd3, 8'h55, 8'h00, exp_crc, 1'b1);
        chk("err_lat", 32'(rsp_cyc - acc_cyc), 32'd1);
        chk("err_reqs", 32'(req_cyc.size()), 32'd0);
        e = ref_crc(exp_crc, 8'h81);
        run(2'd1, 2'd2, 8'h81, 8'h00, e, 1'b0);
        exp_crc = e;
        chk("bus2_count", 32'(n_wr), 32'd8);

        // reset mid-write during bit 4
        send(2'd1, 2'd0, 8'hFF);
        n = 0;
        while (req_cyc.size() < 5 && n < 100) begin @(posedge clock); n++; end
        chk("mid_req_idx", 32'(req_cyc.size()), 32'd5);
        #1 reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        exp_crc = 8'h00; exp_pres = 1'b0;
        @(negedge clock);
        chk("mid_cmd_ready", 32'(sif.cmd_ready), 32'd1);
        chk("mid_busy",      32'(busy),          32'd0);
        chk("mid_rsp_crc",   32'(sif.rsp_crc),   32'd0);
        repeat (6) @(negedge clock);
        chk("mid_late_done", 32'(busy), 32'd0);
        chk("mid_dropped",   32'(n_wr), 32'd5);
        rd_byte = 8'h5A;
        e = ref_crc(8'h00, 8'h5A);
        run(2'd2, 2'd1, 8'h00, 8'h5A, e, 1'b0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
